// File: rtl/accum_add.sv
// rtl/accum_add.sv - PE add/accumulate stage: saturating accumulate into a per-PE activation file
module accum_add #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        comp_en_add,
  input  logic [ADDR_W-1:0] out_act_addr_add,
  input  logic [DATA_W-1:0] mult_result_add,
  input  logic              clr_acc,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic              sat_flag,
  output logic [CNT_W-1:0]  acc_cnt
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [1:0] EN_ACC = 2'b01;

  logic [DATA_W-1:0] acc [DEPTH];

  logic              wb_valid;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_sum;
  logic              wb_sat;

  logic              is_acc;
  logic [DATA_W-1:0] operand;
  logic [DATA_W:0]   sum_ext;
  logic              sum_ovf;
  logic [DATA_W-1:0] sum_sat;
  logic [DATA_W-1:0] rd_next;

  // The pending writeback is the newest value of its address, so both the
  // adder and the read-out port take it in preference to the file.
  always_comb begin
    is_acc  = (comp_en_add == EN_ACC);
    operand = acc[out_act_addr_add];
    if (wb_valid && (wb_addr == out_act_addr_add)) begin
      operand = wb_sum;
    end
    sum_ext = {operand[DATA_W-1], operand} + {mult_result_add[DATA_W-1], mult_result_add};
    sum_ovf = sum_ext[DATA_W] ^ sum_ext[DATA_W-1];
    sum_sat = sum_ext[DATA_W-1:0];
    if (sum_ovf) begin
      sum_sat = sum_ext[DATA_W] ? SAT_MIN : SAT_MAX;
    end
    rd_next = acc[rd_addr];
    if (wb_valid && (wb_addr == rd_addr)) begin
      rd_next = wb_sum;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        acc[i] <= '0;
      end
    end else if (clr_acc) begin
      for (int i = 0; i < DEPTH; i++) begin
        acc[i] <= '0;
      end
    end else if (wb_valid) begin
      acc[wb_addr] <= wb_sum;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid <= 1'b0;
      wb_addr  <= '0;
      wb_sum   <= '0;
      wb_sat   <= 1'b0;
    end else if (clr_acc) begin
      wb_valid <= 1'b0;
    end else begin
      wb_valid <= is_acc;
      if (is_acc) begin
        wb_addr <= out_act_addr_add;
        wb_sum  <= sum_sat;
        wb_sat  <= sum_ovf;
      end
    end
  end

  // Count and saturation are credited when the op commits to the file.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_cnt  <= '0;
      sat_flag <= 1'b0;
    end else if (clr_acc) begin
      acc_cnt  <= '0;
      sat_flag <= 1'b0;
    end else if (wb_valid) begin
      acc_cnt <= acc_cnt + CNT_W'(1);
      if (wb_sat) begin
        sat_flag <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_data <= rd_next;
      end
    end
  end

  assign busy = wb_valid;

endmodule

// File: tb/tb_accum_add.sv
// tb/tb_accum_add.sv - directed bench for accum_add with a read-out scoreboard
module tb_accum_add;

  logic        clk;
  logic        rst_n;
  logic [1:0]  comp_en_add;
  logic [3:0]  out_act_addr_add;
  logic [15:0] mult_result_add;
  logic        clr_acc;
  logic        rd_en;
  logic [3:0]  rd_addr;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        busy;
  logic        sat_flag;
  logic [15:0] acc_cnt;

  int total = 0;
  int bad   = 0;

  int          model [16];
  int          m_cnt;
  logic        m_sat;
  logic [15:0] rd_q [$];

  accum_add #(.DATA_W(16), .ADDR_W(4), .CNT_W(16)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .comp_en_add      (comp_en_add),
    .out_act_addr_add (out_act_addr_add),
    .mult_result_add  (mult_result_add),
    .clr_acc          (clr_acc),
    .rd_en            (rd_en),
    .rd_addr          (rd_addr),
    .rd_data          (rd_data),
    .rd_valid         (rd_valid),
    .busy             (busy),
    .sat_flag         (sat_flag),
    .acc_cnt          (acc_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) model[i] = 0;
    m_cnt = 0;
    m_sat = 1'b0;
  endtask

  // One cycle: drive inputs, update the reference model, clock, then score read-out.
  task automatic drive(input logic [1:0] en, input logic [3:0] addr, input logic [15:0] prod,
                       input logic rd, input logic [3:0] raddr, input logic clr);
    int s;
    logic [15:0] got;
    comp_en_add      = en;
    out_act_addr_add = addr;
    mult_result_add  = prod;
    rd_en            = rd;
    rd_addr          = raddr;
    clr_acc          = clr;
    if (rd) rd_q.push_back(16'(model[raddr]));
    if (clr) begin
      model_clear();
    end else if (en == 2'b01) begin
      s = model[addr] + int'($signed(prod));
      if (s > 32767) begin s = 32767; m_sat = 1'b1; end
      if (s < -32768) begin s = -32768; m_sat = 1'b1; end
      model[addr] = s;
      m_cnt++;
    end
    @(posedge clk);
    #1;
    chk("rd_valid", {31'b0, rd_valid}, {31'b0, rd});
    if (rd_valid) begin
      if (rd_q.size() == 0) begin
        chk("rd_unexpected", 32'd1, 32'd0);
      end else begin
        got = rd_q.pop_front();
        chk("rd_data", {16'b0, rd_data}, {16'b0, got});
      end
    end
  endtask

  task automatic idle();
    drive(2'b00, 4'd0, 16'd0, 1'b0, 4'd0, 1'b0);
  endtask

  task automatic rd(input logic [3:0] a);
    drive(2'b00, 4'd0, 16'd0, 1'b1, a, 1'b0);
  endtask

  task automatic acc_op(input logic [3:0] a, input logic [15:0] p);
    drive(2'b01, a, p, 1'b0, 4'd0, 1'b0);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 20) begin
      idle();
      n++;
    end
    chk("busy_timeout", {31'b0, busy}, 32'd0);
  endtask

  task automatic chk_stats(input string tag);
    chk({tag, "_cnt"}, {16'b0, acc_cnt}, 32'(m_cnt));
    chk({tag, "_sat"}, {31'b0, sat_flag}, {31'b0, m_sat});
  endtask

  initial begin
    model_clear();
    rst_n = 1'b0;
    comp_en_add = 2'b00; out_act_addr_add = '0; mult_result_add = '0;
    clr_acc = 1'b0; rd_en = 1'b0; rd_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rd_data", {16'b0, rd_data}, 32'd0);
    chk("rst_rd_valid", {31'b0, rd_valid}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk_stats("rst");
    rst_n = 1'b1;
    idle();

    // running sum on one address, back to back
    acc_op(4'd2, 16'd5);
    chk("busy_after_acc", {31'b0, busy}, 32'd1);
    acc_op(4'd2, -16'sd3);
    acc_op(4'd2, 16'd10);
    wait_idle();
    rd(4'd2);
    chk_stats("sum3");

    // read right after an ACC is served by forwarding, later read from the file
    acc_op(4'd1, 16'd7);
    rd(4'd1);
    idle();
    rd(4'd1);
    idle();

    // interleaved addresses, plus non-ACC enables that must be ignored
    acc_op(4'd0, 16'd100);
    acc_op(4'd15, 16'd200);
    drive(2'b10, 4'd3, 16'd55, 1'b0, 4'd0, 1'b0);
    drive(2'b11, 4'd3, 16'd66, 1'b0, 4'd0, 1'b0);
    acc_op(4'd0, 16'd100);
    acc_op(4'd15, 16'd200);
    rd(4'd0);
    rd(4'd15);
    rd(4'd3);
    idle();

    // positive saturation, then a large negative product off the clamp
    acc_op(4'd4, 16'h7FF0);
    acc_op(4'd4, 16'h0100);
    wait_idle();
    rd(4'd4);
    chk_stats("sat_pos");
    acc_op(4'd4, 16'h8000);
    rd(4'd4);
    idle();
    chk_stats("sat_sticky");

    // clear drops a same-cycle ACC and a pending writeback; same-cycle read sees old value
    acc_op(4'd5, 16'd9);
    drive(2'b01, 4'd5, 16'd4, 1'b1, 4'd5, 1'b1);
    chk("clr_busy", {31'b0, busy}, 32'd0);
    rd(4'd5);
    rd(4'd4);
    idle();
    chk_stats("clr");
    acc_op(4'd5, 16'd1);
    rd(4'd5);
    idle();
    chk_stats("post_clr");

    // asynchronous reset while a writeback is pending
    acc_op(4'd6, 16'd3);
    chk("pre_rst_busy", {31'b0, busy}, 32'd1);
    rst_n = 1'b0;
    #2;
    chk("async_busy", {31'b0, busy}, 32'd0);
    chk("async_rd_data", {16'b0, rd_data}, 32'd0);
    chk("async_cnt", {16'b0, acc_cnt}, 32'd0);
    model_clear();
    rst_n = 1'b1;
    idle();
    rd(4'd6);
    rd(4'd5);
    rd(4'd2);
    idle();
    chk_stats("after_rst");
    chk("queue_empty", 32'(rd_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
